// File: rtl/slice_stream_host.sv
// Host side of the column-parity slice handshake: buffers one state as SLICES
// slices, feeds them to the engine on request and captures the streamed result in place.
module slice_stream_host #(
  parameter int SLICES = 64,
  parameter int WIDTH  = 25,
  parameter int AW     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             par_start,
  input  logic             par_ready,
  input  logic             put_input,
  output logic [WIDTH-1:0] slice_out,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] slice_in
);
  typedef enum logic [2:0] {IDLE, START, FEED, WAIT_OUT, COLLECT, FIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(SLICES - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [SLICES];

  logic             bufWe;
  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;

  // Single write port shared by system loads (IDLE only) and result capture.
  always_comb begin
    bufWe  = 1'b0;
    wrAddr = load_addr;
    wrData = load_data;
    if (!rst) begin
      if (state == IDLE && load_en) begin
        bufWe = 1'b1;
      end else if (state == COLLECT) begin
        bufWe  = 1'b1;
        wrAddr = cnt;
        wrData = slice_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bufWe) mem[wrAddr] <= wrData;
  end

  assign rd_data   = mem[rd_addr];
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign par_start = (state == START) && par_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      slice_out <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            overrun <= 1'b0;
            cnt     <= '0;
            state   <= START;
          end
        end
        START: begin
          if (par_ready) state <= FEED;
        end
        FEED: begin
          if (put_input) begin
            slice_out <= mem[cnt];
            cnt       <= cnt + AW'(1);
            if (cnt == LAST) state <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          // A request here means the engine asked for a 65th slice; flag it, serve nothing.
          if (put_input) overrun <= 1'b1;
          if (out_ready) begin
            cnt   <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          cnt <= cnt + AW'(1);
          if (out_ready || put_input) overrun <= 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
